// File: rtl/dii_event_packetizer_pkg.sv
// DII flit definitions shared by the event packetizer and its interface.
// Holds the flit struct, flit assembly helper and the FLAGS header field layout.
// Optional feature macro used by the packetizer: DII_PKTZ_TIMESTAMP_EN.
package dii_event_packetizer_pkg;

  // One flit on the DII interconnect.
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  // FLAGS header word layout.
  localparam int DII_FLAG_TYPE_MSB     = 15;
  localparam int DII_FLAG_TYPE_LSB     = 14;
  localparam int DII_FLAG_TYPE_SUB_MSB = 13;
  localparam int DII_FLAG_TYPE_SUB_LSB = 10;

  localparam logic [1:0] DII_TYPE_EVENT    = 2'b10;
  localparam logic [3:0] DII_TYPE_SUB_LAST = 4'h0;
  localparam logic [3:0] DII_TYPE_SUB_CONT = 4'h1;

  function automatic dii_flit dii_flit_assemble(input logic        valid,
                                                input logic        last,
                                                input logic [15:0] data);
    dii_flit f;
    f.valid = valid;
    f.last  = last;
    f.data  = data;
    return f;
  endfunction

  // FLAGS word of an event packet; low bits reserved as zero.
  function automatic logic [15:0] dii_event_flags(input logic [3:0] type_sub);
    logic [15:0] w;
    w = '0;
    w[DII_FLAG_TYPE_MSB:DII_FLAG_TYPE_LSB]         = DII_TYPE_EVENT;
    w[DII_FLAG_TYPE_SUB_MSB:DII_FLAG_TYPE_SUB_LSB] = type_sub;
    return w;
  endfunction

endpackage

// File: rtl/dii_event_packetizer_if.sv
// Event request, payload stream and flit output of the DII event packetizer.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; a source holds valid and its data steady until the transfer.
// master = packetizer side, slave = event source / interconnect side.
interface dii_event_packetizer_if #(
  parameter int LEN_W = 8
);
  import dii_event_packetizer_pkg::*;

  logic             evt_valid;
  logic             evt_ready;
  logic [15:0]      evt_dest;
  logic [LEN_W-1:0] evt_len;
  logic             data_valid;
  logic [15:0]      data;
  logic             data_ready;
  dii_flit          flit_out;
  logic             flit_out_ready;

  modport master (
    input  evt_valid, evt_dest, evt_len, data_valid, data, flit_out_ready,
    output evt_ready, data_ready, flit_out
  );

  modport slave (
    output evt_valid, evt_dest, evt_len, data_valid, data, flit_out_ready,
    input  evt_ready, data_ready, flit_out
  );

endinterface

// File: rtl/dii_event_packetizer.sv
// DII event packetizer: turns an event request plus 16-bit payload words into
// DEST/SRC/FLAGS headed flit packets, splitting long events into several packets.
// `define DII_PKTZ_TIMESTAMP_EN adds a free-running 32-bit timestamp sent as
// TS_LO/TS_HI after FLAGS in the first packet of each event.
module dii_event_packetizer
  import dii_event_packetizer_pkg::*;
#(
  parameter int MAX_PKT_LEN = 8,
  parameter int LEN_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            id,
  dii_event_packetizer_if.master bus,
  output logic                   busy,
  output logic [2:0]             state_dbg
);

  localparam int CNT_W = $clog2(MAX_PKT_LEN);
  localparam int CAP   = MAX_PKT_LEN - 3;
`ifdef DII_PKTZ_TIMESTAMP_EN
  localparam int CAP_FIRST = MAX_PKT_LEN - 5;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DEST = 3'd1, S_SRC = 3'd2, S_FLAGS = 3'd3,
    S_TS_LO = 3'd4, S_TS_HI = 3'd5, S_PAYLOAD = 3'd6
  } state_t;
`else
  localparam int CAP_FIRST = CAP;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DEST = 3'd1, S_SRC = 3'd2, S_FLAGS = 3'd3, S_PAYLOAD = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [15:0]      dest_q;
  logic [LEN_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             first_q;
  logic [LEN_W-1:0] cap_cur;
  logic             cont;
  logic             pay_last;
  logic             evt_fire;
  logic             pay_fire;

  // Payload capacity of the current packet, and whether more packets follow.
  always_comb begin
    cap_cur  = first_q ? LEN_W'(CAP_FIRST) : LEN_W'(CAP);
    cont     = rem_q > cap_cur;
    pay_last = (cnt_q == CNT_W'(cap_cur - LEN_W'(1))) || (rem_q == LEN_W'(1));
    evt_fire = (state_q == S_IDLE) && bus.evt_valid;
    pay_fire = (state_q == S_PAYLOAD) && bus.data_valid && bus.flit_out_ready;
  end

`ifdef DII_PKTZ_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_q;

  // Free-running timestamp, captured when an event is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (evt_fire) ts_q <= ts_cnt_q;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Event latch, remaining word count and per-packet word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else if (evt_fire) begin
      dest_q  <= bus.evt_dest;
      rem_q   <= bus.evt_len;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else if (pay_fire) begin
      rem_q <= rem_q - LEN_W'(1);
      if (pay_last) begin
        cnt_q   <= '0;
        first_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state: header flits advance on flit_out_ready, payload on each accepted word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.evt_valid) state_d = S_DEST;
      S_DEST:  if (bus.flit_out_ready) state_d = S_SRC;
      S_SRC:   if (bus.flit_out_ready) state_d = S_FLAGS;
`ifdef DII_PKTZ_TIMESTAMP_EN
      S_FLAGS: if (bus.flit_out_ready) begin
        if (first_q)             state_d = S_TS_LO;
        else if (rem_q == '0)    state_d = S_IDLE;
        else                     state_d = S_PAYLOAD;
      end
      S_TS_LO: if (bus.flit_out_ready) state_d = S_TS_HI;
      S_TS_HI: if (bus.flit_out_ready) state_d = (rem_q == '0) ? S_IDLE : S_PAYLOAD;
`else
      S_FLAGS: if (bus.flit_out_ready) state_d = (rem_q == '0) ? S_IDLE : S_PAYLOAD;
`endif
      S_PAYLOAD: if (pay_fire && pay_last)
        state_d = (rem_q == LEN_W'(1)) ? S_IDLE : S_DEST;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: header flits from registers, payload passed straight through.
  always_comb begin
    bus.evt_ready  = 1'b0;
    bus.data_ready = 1'b0;
    bus.flit_out   = '0;
    busy           = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus.evt_ready = 1'b1;
        busy          = 1'b0;
      end
      S_DEST:  bus.flit_out = dii_flit_assemble(1'b1, 1'b0, dest_q);
      S_SRC:   bus.flit_out = dii_flit_assemble(1'b1, 1'b0, id);
`ifdef DII_PKTZ_TIMESTAMP_EN
      S_FLAGS: bus.flit_out = dii_flit_assemble(1'b1, (rem_q == '0) && !first_q,
        dii_event_flags(cont ? DII_TYPE_SUB_CONT : DII_TYPE_SUB_LAST));
      S_TS_LO: bus.flit_out = dii_flit_assemble(1'b1, 1'b0, ts_q[15:0]);
      S_TS_HI: bus.flit_out = dii_flit_assemble(1'b1, rem_q == '0, ts_q[31:16]);
`else
      S_FLAGS: bus.flit_out = dii_flit_assemble(1'b1, rem_q == '0,
        dii_event_flags(cont ? DII_TYPE_SUB_CONT : DII_TYPE_SUB_LAST));
`endif
      S_PAYLOAD: begin
        bus.flit_out   = dii_flit_assemble(bus.data_valid, pay_last, bus.data);
        bus.data_ready = bus.flit_out_ready;
      end
      default: bus.flit_out = '0;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_dii_event_packetizer.sv
// Self-checking bench for dii_event_packetizer (MAX_PKT_LEN=8, id=0x0012, dest=0x0005).
module tb_dii_event_packetizer;
  import dii_event_packetizer_pkg::*;

  localparam int          MAX_PKT_LEN = 8;
  localparam logic [15:0] ID          = 16'h0012;
  localparam logic [15:0] DEST        = 16'h0005;
`ifdef DII_PKTZ_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id;
  logic        busy;
  logic [2:0]  state_dbg;

  dii_event_packetizer_if #(.LEN_W(8)) bus ();

  dii_event_packetizer #(.MAX_PKT_LEN(MAX_PKT_LEN), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .id        (id),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock / reset-related model state.
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  logic [15:0] data_q[$];
  bit          gaps = 1'b0;
  int          stall_viol = 0;
  int          dr_cnt = 0;
  logic [31:0] tb_cyc;
  logic [31:0] exp_ts = '0;
  logic        prev_stall = 1'b0;
  dii_flit     prev_flit;
  logic        data_fire;

  always @(posedge clk) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  // Flit capture at negedge, payload source and downstream ready after posedge.
  always begin
    @(negedge clk);
    data_fire = 1'b0;
    if (!rst) begin
      if (bus.flit_out.valid && bus.flit_out_ready)
        got_q.push_back({bus.flit_out.last, bus.flit_out.data});
      if (prev_stall && bus.flit_out.valid && (bus.flit_out !== prev_flit))
        stall_viol++;
      prev_stall = bus.flit_out.valid && !bus.flit_out_ready;
      prev_flit  = bus.flit_out;
      if (bus.data_ready) dr_cnt++;
      data_fire = bus.data_valid && bus.data_ready;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    if (data_fire && data_q.size() > 0) void'(data_q.pop_front());
    bus.data_valid     = (data_q.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
    bus.data           = (data_q.size() > 0) ? data_q[0] : 16'h0000;
    bus.flit_out_ready = !gaps || ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    dr_cnt     = 0;
    stall_viol = 0;
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) data_q.push_back(base + 16'(i));
  endtask

  task automatic start_event(input logic [15:0] dest, input logic [7:0] len);
    int n = 0;
    @(posedge clk);
    #1;
    bus.evt_valid = 1'b1;
    bus.evt_dest  = dest;
    bus.evt_len   = len;
    @(negedge clk);
    while (!bus.evt_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp_ts = tb_cyc;
    checks++;
    if (bus.evt_ready !== 1'b1) begin
      errors++;
      $display("FAIL evt_accept: evt_ready=%b required 1", bus.evt_ready);
    end
    @(posedge clk);
    #1;
    bus.evt_valid = 1'b0;
    bus.evt_len   = '0;
  endtask

  task automatic wait_flits(input int n, input int extra);
    int c = 0;
    while (got_q.size() < n && c < 500) begin
      @(negedge clk);
      #1;
      c++;
    end
    repeat (extra) @(negedge clk);
  endtask

  // Reference packet model: expected {last,data} flits for one event.
  task automatic build_exp(input logic [15:0] dest, input int len,
                           input logic [15:0] base, input logic [31:0] ts);
    int          rem = len;
    int          idx = 0;
    bit          first = 1'b1;
    int          cap;
    int          n;
    logic [15:0] flags;
    do begin
      cap   = (TS_ON && first) ? MAX_PKT_LEN - 5 : MAX_PKT_LEN - 3;
      n     = (rem > cap) ? cap : rem;
      flags = (rem > cap) ? 16'h8400 : 16'h8000;
      exp_q.push_back({1'b0, dest});
      exp_q.push_back({1'b0, ID});
      if (TS_ON && first) begin
        exp_q.push_back({1'b0, flags});
        exp_q.push_back({1'b0, ts[15:0]});
        exp_q.push_back({(n == 0), ts[31:16]});
      end else begin
        exp_q.push_back({(n == 0), flags});
      end
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({(k == n - 1), base + 16'(idx)});
        idx++;
      end
      rem   = rem - n;
      first = 1'b0;
    end while (rem > 0);
  endtask

  // Tests.
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.flit_out.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.flit_out.valid); end
    checks++;
    if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b required 0", bus.data_ready); end
    checks++;
    if (bus.evt_ready !== 1'b1) begin errors++; $display("FAIL reset_evt_ready: got %b required 1", bus.evt_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    clear_sb();
    push_words(16'h00A1, 3);
    data_q.push_back(16'hEEEE);
    start_event(DEST, 8'd3);
`ifdef DII_PKTZ_TIMESTAMP_EN
    build_exp(DEST, 3, 16'h00A1, exp_ts);
`else
    exp_q = '{17'h00005, 17'h00012, 17'h08000, 17'h000A1, 17'h000A2, 17'h100A3};
`endif
    wait_flits(exp_q.size(), 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_flit%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 17'h0, exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    checks++;
    if (bus.evt_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: evt_ready=%b busy=%b required 1 0", bus.evt_ready, busy); end
    checks++;
    if (data_q.size() != 1) begin errors++; $display("FAIL single_extra_word: %0d words pending required 1", data_q.size()); end
  endtask

  task automatic test_len_zero();
    clear_sb();
    start_event(DEST, 8'd0);
`ifdef DII_PKTZ_TIMESTAMP_EN
    build_exp(DEST, 0, 16'h0000, exp_ts);
`else
    exp_q = '{17'h00005, 17'h00012, 17'h18000};
`endif
    wait_flits(exp_q.size(), 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL len0_flit%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 17'h0, exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL len0_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    checks++;
    if (dr_cnt != 0) begin errors++; $display("FAIL len0_data_ready: asserted %0d cycles required 0", dr_cnt); end
    checks++;
    if (data_q.size() != 1) begin errors++; $display("FAIL len0_word_kept: %0d words pending required 1", data_q.size()); end
    @(posedge clk);
    #2;
    data_q.delete();
  endtask

  task automatic test_multi_packet(input int len, input logic [15:0] base, input bit use_gaps);
    clear_sb();
    gaps = use_gaps;
    push_words(base, len);
    start_event(DEST, 8'(len));
    build_exp(DEST, len, base, exp_ts);
    wait_flits(exp_q.size(), 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL multi_len%0d_gaps%0d_flit%0d: got %h required %h", len, use_gaps, i,
                 (i < got_q.size()) ? got_q[i] : 17'h0, exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL multi_len%0d_count: got %0d required %0d", len, got_q.size(), exp_q.size()); end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL multi_len%0d_stall_stable: %0d changes while stalled required 0", len, stall_viol); end
    checks++;
    if (data_q.size() != 0) begin errors++; $display("FAIL multi_len%0d_consumed: %0d words left required 0", len, data_q.size()); end
    gaps = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    clear_sb();
    push_words(16'hD101, 5);
    start_event(DEST, 8'd5);
    wait_flits(4, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.flit_out.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", bus.flit_out.valid); end
    checks++;
    if (bus.evt_ready !== 1'b1) begin errors++; $display("FAIL midrst_evt_ready: got %b required 1", bus.evt_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    clear_sb();
    data_q.delete();
    data_q.push_back(16'hD201);
    start_event(DEST, 8'd1);
    build_exp(DEST, 1, 16'hD201, exp_ts);
    wait_flits(exp_q.size(), 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_fresh_flit%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 17'h0, exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_fresh_count: got %0d required %0d", got_q.size(), exp_q.size()); end
  endtask

`ifdef DII_PKTZ_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [16:0] lit[$];
    clear_sb();
    push_words(16'hE001, 4);
    start_event(DEST, 8'd4);
    lit = '{17'h00005, 17'h00012, 17'h08400, {1'b0, exp_ts[15:0]}, {1'b0, exp_ts[31:16]},
            17'h0E001, 17'h0E002, 17'h1E003, 17'h00005, 17'h00012, 17'h08000, 17'h1E004};
    exp_q = lit;
    wait_flits(exp_q.size(), 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ts_flit%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 17'h0, exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ts_count: got %0d required %0d", got_q.size(), exp_q.size()); end
  endtask
`endif

  initial begin
    rst                = 1'b1;
    id                 = ID;
    bus.evt_valid      = 1'b0;
    bus.evt_dest       = '0;
    bus.evt_len        = '0;
    bus.data_valid     = 1'b0;
    bus.data           = '0;
    bus.flit_out_ready = 1'b1;
    prev_flit          = '0;
    test_reset();
    test_single_packet();
    test_len_zero();
    test_multi_packet(12, 16'hB000, 1'b0);
    test_multi_packet(5, 16'hB100, 1'b0);
    test_multi_packet(12, 16'hC000, 1'b1);
    test_reset_mid_packet();
`ifdef DII_PKTZ_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
